// File: rtl/acc_seq_engine.sv
`default_nettype none
// ============================================================================
// Module   : acc_seq_engine
// Brief    : Prescaled FETCH/EXEC/WRITE accumulator sequencer; define
//            ACC_SAT_EN to saturate ADD/SUB instead of wrapping.
// Revision : 1.0
// ============================================================================
module acc_seq_engine #(
    parameter int WIDTH    = 8,
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] operand,
    input  logic [CNT_W-1:0] iterations,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc_out,
    output logic             out_strobe,
    output logic             carry,
    output logic             zero
);

    localparam int              c_PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(PRESCALE - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_EXEC  = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
    localparam logic [2:0] c_FIN   = 3'd4;

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_NOT = 3'd5;
    localparam logic [2:0] c_OP_SHL = 3'd6;
    localparam logic [2:0] c_OP_SHR = 3'd7;

    logic [2:0]       r_state, w_state_nxt;
    logic [c_PW-1:0]  r_presc;
    logic [CNT_W-1:0] r_cnt, r_iters;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_operand, r_a, r_acc;
    logic [WIDTH:0]   r_result, w_alu;
    logic             r_carry, r_zero, r_strobe, r_done;

    logic w_tick, w_accept, w_clear, w_last;
    logic w_do_fetch, w_do_exec, w_do_write, w_do_fin;

    assign w_tick   = (r_presc == c_PMAX);
    // The done cycle is still IDLE, but a start seen there must not launch a run.
    assign w_accept = (r_state == c_IDLE) && start && !clear && !r_done;
    assign w_clear  = (r_state == c_IDLE) && clear;
    assign w_last   = ((r_cnt + CNT_W'(1)) == r_iters);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_nxt = (iterations == '0) ? c_FIN : c_FETCH;
            c_FETCH: if (w_tick) w_state_nxt = c_EXEC;
            c_EXEC:  if (w_tick) w_state_nxt = c_WRITE;
            c_WRITE: if (w_tick) w_state_nxt = w_last ? c_FIN : c_FETCH;
            c_FIN:   w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_do_fetch = 1'b0;
        w_do_exec  = 1'b0;
        w_do_write = 1'b0;
        w_do_fin   = 1'b0;
        case (r_state)
            c_FETCH: w_do_fetch = w_tick;
            c_EXEC:  w_do_exec  = w_tick;
            c_WRITE: w_do_write = w_tick;
            c_FIN:   w_do_fin   = 1'b1;
            default: ;
        endcase
    end

    // Bit WIDTH carries carry, borrow or the shifted-out bit depending on op.
    always_comb begin
        w_alu = '0;
        case (r_op)
            c_OP_ADD: w_alu = {1'b0, r_a} + {1'b0, r_operand};
            c_OP_SUB: w_alu = {1'b0, r_a} - {1'b0, r_operand};
            c_OP_AND: w_alu = {1'b0, r_a & r_operand};
            c_OP_OR:  w_alu = {1'b0, r_a | r_operand};
            c_OP_XOR: w_alu = {1'b0, r_a ^ r_operand};
            c_OP_NOT: w_alu = {1'b0, ~r_a};
            c_OP_SHL: w_alu = {r_a, 1'b0};
            c_OP_SHR: w_alu = {r_a[0], 1'b0, r_a[WIDTH-1:1]};
            default:  w_alu = '0;
        endcase
`ifdef ACC_SAT_EN
        if (w_alu[WIDTH] && (r_op == c_OP_ADD)) w_alu = {1'b1, {WIDTH{1'b1}}};
        if (w_alu[WIDTH] && (r_op == c_OP_SUB)) w_alu = {1'b1, {WIDTH{1'b0}}};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_presc <= '0;
        else if (w_accept || w_tick) r_presc <= '0;
        else r_presc <= r_presc + c_PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_iters   <= '0;
            r_op      <= '0;
            r_operand <= '0;
            r_a       <= '0;
            r_result  <= '0;
            r_acc     <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b1;
            r_strobe  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_strobe <= w_do_write;
            r_done   <= w_do_fin;
            if (w_clear) begin
                r_acc   <= '0;
                r_zero  <= 1'b1;
                r_carry <= 1'b0;
            end
            if (w_accept) begin
                r_op      <= alu_op;
                r_operand <= operand;
                r_iters   <= iterations;
                r_cnt     <= '0;
            end
            if (w_do_fetch) r_a <= r_acc;
            if (w_do_exec)  r_result <= w_alu;
            if (w_do_write) begin
                r_acc   <= r_result[WIDTH-1:0];
                r_carry <= r_result[WIDTH];
                r_zero  <= (r_result[WIDTH-1:0] == '0);
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign busy       = (r_state != c_IDLE);
    assign done       = r_done;
    assign acc_out    = r_acc;
    assign out_strobe = r_strobe;
    assign carry      = r_carry;
    assign zero       = r_zero;

endmodule
`default_nettype wire
